// File: rtl/dm_resp_pkg.sv
// -----------------------------------------------------------------------------
// dm_resp_pkg
// Shared types and constants for the data-memory responder.
//   - dm_state_e         : responder FSM states
//   - DM_CNT_W           : wait-state counter width (supports 0..15 waits)
//   - DM_*_DEF           : default parameter values for the responder
// -----------------------------------------------------------------------------
package dm_resp_pkg;

  localparam int DM_CNT_W           = 4;
  localparam int DM_DATA_W          = 32;
  localparam int DM_ADDR_WIDTH_DEF  = 8;
  localparam int DM_WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request
    ST_WAIT = 2'd1,  // burning programmed wait states
    ST_DONE = 2'd2,  // one-cycle completion (mem_ready)
    ST_HOLD = 2'd3   // waiting for the CPU to drop its request
  } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// -----------------------------------------------------------------------------
// dm_ram
// 2^ADDR_WIDTH x 32-bit word array: synchronous write, combinational read on
// the same word index. The responder registers the read data itself.
// Ports:
//   clk      in   clock
//   i_we     in   write enable (commit on rising edge)
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  combinational read data at i_addr
// -----------------------------------------------------------------------------
module dm_ram
  import dm_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DM_DATA_W-1:0]  i_wdata,
  output logic [DM_DATA_W-1:0]  o_rdata
);

  logic [DM_DATA_W-1:0] r_mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset; contents survive reset and stay mappable
  // onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the multicycle CPU load/store interface. Accepts a
// held memory_read/memory_write request, inserts WAIT_CYCLES wait states,
// commits the write or loads data_out, pulses mem_ready for one cycle, then
// waits for the request to drop before accepting another.
// Optional feature macro: DM_ALIGN_CHECK_EN (misaligned accesses become
// no-ops flagged by addr_error during the DONE cycle).
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   memory_read   in   read request (held until mem_ready)
//   memory_write  in   write request (held until mem_ready); wins over read
//   data_address  in   byte address; word index = [ADDR_WIDTH+1:2]
//   data_in       in   write data
//   data_out      out  registered read data, held until next completed read
//   mem_ready     out  one-cycle completion pulse
//   busy          out  high whenever the FSM is not IDLE
//   addr_error    out  misaligned access flag (0 unless DM_ALIGN_CHECK_EN)
// -----------------------------------------------------------------------------
module data_mem_responder
  import dm_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = DM_ADDR_WIDTH_DEF,
  parameter int WAIT_CYCLES = DM_WAIT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memory_read,
  input  logic                 memory_write,
  input  logic [31:0]          data_address,
  input  logic [DM_DATA_W-1:0] data_in,
  output logic [DM_DATA_W-1:0] data_out,
  output logic                 mem_ready,
  output logic                 busy,
  output logic                 addr_error
);

  localparam bit                LP_NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [DM_CNT_W-1:0] LP_CNT_LOAD =
    LP_NO_WAIT ? '0 : DM_CNT_W'(WAIT_CYCLES - 1);

  dm_state_e             r_state;
  dm_state_e             w_next_state;
  logic [DM_CNT_W-1:0]   r_cnt;
  logic                  r_op_write;
  logic                  r_misalign;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DM_DATA_W-1:0]  r_wdata;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_in_misalign;
  logic                  w_commit;
  logic                  w_use_live;
  logic                  w_op_write;
  logic                  w_misalign;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DM_DATA_W-1:0]  w_wdata;
  logic [DM_DATA_W-1:0]  w_rdata;
  logic                  w_ram_we;
  logic                  w_load_dout;
  logic                  w_unused_addr;

  assign w_req    = memory_read | memory_write;
  assign w_accept = (r_state == ST_IDLE) && w_req;

`ifdef DM_ALIGN_CHECK_EN
  assign w_in_misalign = |data_address[1:0];
`else
  assign w_in_misalign = 1'b0;
`endif

  // Upper address bits wrap away; byte offset only matters with the check on.
  assign w_unused_addr = ^{data_address[31:ADDR_WIDTH+2], data_address[1:0]};

  // Commit happens on the edge that enters DONE. With zero wait states that is
  // the acceptance edge itself, so the live request inputs must be used there
  // because the latched copies are only being written on that same edge.
  assign w_commit   = (w_accept && LP_NO_WAIT) ||
                      ((r_state == ST_WAIT) && (r_cnt == '0));
  assign w_use_live = (r_state == ST_IDLE);
  assign w_op_write = w_use_live ? memory_write  : r_op_write;
  assign w_misalign = w_use_live ? w_in_misalign : r_misalign;
  assign w_idx      = w_use_live ? data_address[ADDR_WIDTH+1:2] : r_idx;
  assign w_wdata    = w_use_live ? data_in : r_wdata;

  assign w_ram_we    = w_commit &&  w_op_write && !w_misalign;
  assign w_load_dout = w_commit && !w_op_write && !w_misalign;

  dm_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path leaves w_next_state unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req)        w_next_state = LP_NO_WAIT ? ST_DONE : ST_WAIT;
      ST_WAIT: if (r_cnt == '0)  w_next_state = ST_DONE;
      ST_DONE:                   w_next_state = ST_HOLD;
      ST_HOLD: if (!w_req)       w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state so reset clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ready  = (r_state == ST_DONE);
    busy       = (r_state != ST_IDLE);
`ifdef DM_ALIGN_CHECK_EN
    addr_error = (r_state == ST_DONE) && r_misalign;
`else
    addr_error = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Request capture, wait counter and read-data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op_write <= 1'b0;
      r_misalign <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      data_out   <= '0;
    end else begin
      if (w_accept) begin
        r_op_write <= memory_write;
        r_misalign <= w_in_misalign;
        r_idx      <= data_address[ADDR_WIDTH+1:2];
        r_wdata    <= data_in;
        r_cnt      <= LP_CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - DM_CNT_W'(1);
      end

      if (w_load_dout) begin
        data_out <= w_rdata;
      end
    end
  end

endmodule
